// File: rtl/pipe_cla_addsub_if.sv
// Operand/result bundle for pipe_cla_addsub: input handshake, operands, and the
// flagged result returned with its tag.
interface pipe_cla_addsub_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             c_in_i;
    logic [1:0]       op_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] s_o;
    logic             c_out_o;
    logic             ovf_o;
    logic             zero_o;
    logic [TAG_W-1:0] tag_o;

    modport master (
        output in_valid_i, a_i, b_i, c_in_i, op_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, s_o, c_out_o, ovf_o, zero_o, tag_o
    );

    modport slave (
        input  in_valid_i, a_i, b_i, c_in_i, op_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, s_o, c_out_o, ovf_o, zero_o, tag_o
    );
endinterface

// File: rtl/pipe_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one SEG_W-bit segment resolved per
// stage, inter-segment carry registered, whole pipe advancing on a single enable.
module pipe_cla_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG_W = 8,
    parameter int unsigned TAG_W = 4
) (
    input logic           clk_i,
    input logic           rst_i,
    pipe_cla_addsub_if.slave bus
);
    localparam int unsigned N = WIDTH / SEG_W;

    if ((WIDTH % SEG_W) != 0 || N < 1) begin : g_param_check
        $error("pipe_cla_addsub: WIDTH must be a non-zero multiple of SEG_W");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    logic             v_q [N];
    logic             v_d [N];
    logic [WIDTH-1:0] a_q [N];
    logic [WIDTH-1:0] a_d [N];
    logic [WIDTH-1:0] b_q [N];
    logic [WIDTH-1:0] b_d [N];
    logic [WIDTH-1:0] s_q [N];
    logic [WIDTH-1:0] s_d [N];
    logic             c_q [N];
    logic             c_d [N];
    logic             z_q [N];
    logic             z_d [N];
    logic [TAG_W-1:0] t_q [N];
    logic [TAG_W-1:0] t_d [N];
    logic             cm_q;
    logic             cm_d;

    logic [WIDTH-1:0] ai;
    logic [WIDTH-1:0] bi;
    logic [WIDTH-1:0] si;
    logic             cy;
    logic             zi;
    logic [SEG_W-1:0] sa;
    logic [SEG_W-1:0] sb;
    logic [SEG_W-1:0] ss;
    logic             gb;
    logic             pb;

    assign en = ~v_q[N-1] | bus.out_ready_i;

    // op[1] selects subtract (invert B), op[0] selects the external carry-in.
    always_comb begin
        b_eff = bus.op_i[1] ? ~bus.b_i : bus.b_i;
        c0    = bus.op_i[0] ? bus.c_in_i : bus.op_i[1];
    end

    // Stage k resolves segment k; stage 0 is fed straight from the prepared inputs.
    always_comb begin
        cm_d = 1'b0;
        ai   = '0;
        bi   = '0;
        si   = '0;
        cy   = 1'b0;
        zi   = 1'b0;
        sa   = '0;
        sb   = '0;
        ss   = '0;
        gb   = 1'b0;
        pb   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (k == 0) begin
                ai     = bus.a_i;
                bi     = b_eff;
                si     = '0;
                cy     = c0;
                zi     = 1'b1;
                t_d[k] = bus.tag_i;
                v_d[k] = bus.in_valid_i;
            end else begin
                ai     = a_q[k-1];
                bi     = b_q[k-1];
                si     = s_q[k-1];
                cy     = c_q[k-1];
                zi     = z_q[k-1];
                t_d[k] = t_q[k-1];
                v_d[k] = v_q[k-1];
            end
            sa = ai[k*SEG_W +: SEG_W];
            sb = bi[k*SEG_W +: SEG_W];
            for (int unsigned i = 0; i < SEG_W; i++) begin
                gb    = sa[i] & sb[i];
                pb    = sa[i] | sb[i];
                ss[i] = sa[i] ^ sb[i] ^ cy;
                if (k == N - 1 && i == SEG_W - 1) begin
                    cm_d = cy;
                end
                cy = gb | (pb & cy);
            end
            si[k*SEG_W +: SEG_W] = ss;
            a_d[k] = ai;
            b_d[k] = bi;
            s_d[k] = si;
            c_d[k] = cy;
            z_d[k] = zi & (ss == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < N; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                z_q[k] <= 1'b0;
                t_q[k] <= '0;
            end
            cm_q <= 1'b0;
        end else if (en) begin
            for (int unsigned k = 0; k < N; k++) begin
                v_q[k] <= v_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
                z_q[k] <= z_d[k];
                t_q[k] <= t_d[k];
            end
            cm_q <= cm_d;
        end
    end

    assign bus.in_ready_o  = en;
    assign bus.out_valid_o = v_q[N-1];
    assign bus.s_o         = s_q[N-1];
    assign bus.c_out_o     = c_q[N-1];
    assign bus.ovf_o       = cm_q ^ c_q[N-1];
    assign bus.zero_o      = z_q[N-1];
    assign bus.tag_o       = t_q[N-1];
endmodule
